// File: rtl/clk_meter_pkg.sv
// clk_meter_pkg: FSM state type and default parameters shared by the clock period meter.
package clk_meter_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_RISE, MEASURE, HOLD} state_t;
    localparam int          DEF_SYNC_STAGES = 2;
    localparam int          DEF_CNT_W       = 32;
    localparam int unsigned DEF_TIMEOUT     = 100_000_000;
endpackage

// File: rtl/clk_period_meter_sync_edge_det.sv
// sync_edge_det: synchronizes an asynchronous clock and emits single-cycle rise/fall pulses,
// held off for SYNC_STAGES+1 cycles after reset while the chain settles.
module sync_edge_det
    import clk_meter_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk_50m,
    input  logic reset,
    input  logic clk_in,
    output logic rise,
    output logic fall
);
    localparam int WARM = SYNC_STAGES + 1;
    localparam int WW   = $clog2(WARM + 1);
    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("SYNC_STAGES must be at least 2");
    end
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [WW-1:0]          r_warm;
    logic                   w_warm_done;
    logic                   w_sync;
    assign w_warm_done = (r_warm == WW'(WARM));
    assign w_sync      = r_sync[SYNC_STAGES-1];
    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_warm <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], clk_in};
            r_prev <= w_sync;
            if (!w_warm_done) r_warm <= r_warm + 1'b1;
        end
    end
    assign rise = w_warm_done &  w_sync & ~r_prev;
    assign fall = w_warm_done & ~w_sync &  r_prev;
endmodule

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of a slow clock in clk_50m cycles,
// presenting one result per start through a valid/ready handshake.
module clk_period_meter
    import clk_meter_pkg::*;
#(
    parameter int          SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int          CNT_W       = DEF_CNT_W,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
    input  logic             clk_50m,
    input  logic             reset,
    input  logic             clk_in,
    input  logic             start,
    input  logic             ready,
    output logic             valid,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             busy,
    output logic             timeout
);
    if (CNT_W < 64 && 64'(TIMEOUT) >= (64'd1 << CNT_W)) begin : g_bad_timeout
        $error("TIMEOUT must be below 2**CNT_W");
    end
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic [CNT_W-1:0] r_high_cap;
    logic             r_valid;
    logic             r_busy;
    logic             r_timeout;
    logic             w_rise;
    logic             w_fall;
    logic             w_hit;
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_50m (clk_50m),
        .reset   (reset),
        .clk_in  (clk_in),
        .rise    (w_rise),
        .fall    (w_fall)
    );
    assign w_hit = (r_cnt == CNT_W'(TIMEOUT));
    // high time is staged and only published with the period, so an aborted run leaves results intact
    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_period   <= '0;
            r_high     <= '0;
            r_high_cap <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_state    <= WAIT_RISE;
                    r_busy     <= 1'b1;
                    r_cnt      <= '0;
                    r_high_cap <= '0;
                    r_timeout  <= 1'b0;
                end
                WAIT_RISE: if (w_rise) begin
                    r_state <= MEASURE;
                    r_cnt   <= CNT_W'(1);
                end else if (w_hit) begin
                    r_state   <= IDLE;
                    r_busy    <= 1'b0;
                    r_timeout <= 1'b1;
                end else r_cnt <= r_cnt + 1'b1;
                MEASURE: begin
                    if (w_fall) r_high_cap <= r_cnt;
                    if (w_rise) begin
                        r_state  <= HOLD;
                        r_period <= r_cnt;
                        r_high   <= r_high_cap;
                        r_valid  <= 1'b1;
                    end else if (w_hit) begin
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                    end else r_cnt <= r_cnt + 1'b1;
                end
                HOLD: if (ready) begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign valid     = r_valid;
    assign busy      = r_busy;
    assign timeout   = r_timeout;
    assign period    = r_period;
    assign high_time = r_high;
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: table, random and directed checks of the clock period meter
// against expected values derived from the high/low phase lengths of the generated clk_in.
module tb_clk_period_meter;
    localparam int TMO = 1000;
    logic        clk_50m = 1'b0;
    logic        reset   = 1'b1;
    logic        clk_in  = 1'b0;
    logic        start   = 1'b0;
    logic        ready   = 1'b0;
    logic        valid;
    logic [31:0] period;
    logic [31:0] high_time;
    logic        busy;
    logic        timeout;
    int n_tests = 0;
    int n_fail  = 0;
    int hi_len  = 25;
    int lo_len  = 25;
    logic gen_en = 1'b0;
    int last_p = 0;
    int last_h = 0;
    typedef struct {
        string name;
        int    hi;
        int    lo;
        int    ep;
        int    eh;
    } vec_t;
    vec_t tbl[5];
    clk_period_meter #(.SYNC_STAGES(2), .CNT_W(32), .TIMEOUT(TMO)) dut (
        .clk_50m   (clk_50m),
        .reset     (reset),
        .clk_in    (clk_in),
        .start     (start),
        .ready     (ready),
        .valid     (valid),
        .period    (period),
        .high_time (high_time),
        .busy      (busy),
        .timeout   (timeout)
    );
    always #10 clk_50m = ~clk_50m;
    // clk_in changes 3 ns after a clk_50m edge; phase lengths are latched at each rising edge
    initial begin
        int h;
        int l;
        @(posedge clk_50m);
        #3;
        forever begin
            if (!gen_en) begin
                clk_in = 1'b0;
                @(posedge clk_50m);
                #3;
            end else begin
                h = hi_len;
                l = lo_len;
                clk_in = 1'b1;
                repeat (h) @(posedge clk_50m);
                #3;
                clk_in = 1'b0;
                repeat (l) @(posedge clk_50m);
                #3;
            end
        end
    end
    initial begin
        #10ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end
    function automatic int ref_period(input int hi, input int lo);
        return hi + lo;
    endfunction
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask
    task automatic wait_valid(input string tag);
        int n = 0;
        while (!valid && n < 400) begin
            @(negedge clk_50m);
            n++;
        end
        chk({tag, "_valid"}, valid, 1);
    endtask
    task automatic pulse_start();
        @(negedge clk_50m);
        start = 1'b1;
        @(negedge clk_50m);
        start = 1'b0;
    endtask
    task automatic measure(input string tag, input int hi, input int lo, input int ep, input int eh);
        hi_len = hi;
        lo_len = lo;
        gen_en = 1'b1;
        repeat (260) @(negedge clk_50m);
        pulse_start();
        wait_valid(tag);
        chk({tag, "_period"}, period, ep);
        chk({tag, "_high"}, high_time, eh);
        ready = 1'b1;
        @(negedge clk_50m);
        ready = 1'b0;
        chk({tag, "_valid_drop"}, valid, 0);
        last_p = ep;
        last_h = eh;
    endtask
    task automatic wait_clk_in_rise();
        logic prev = clk_in;
        int   n    = 0;
        while (!(clk_in && !prev) && n < 300) begin
            prev = clk_in;
            @(negedge clk_50m);
            n++;
        end
        if (n >= 300) chk("clk_in_rise_seen", 0, 1);
    endtask
    initial begin
        int   n;
        int   bad;
        logic seen;
        tbl[0] = '{"p50h25", 25, 25, 50, 25};
        tbl[1] = '{"p40h10", 10, 30, 40, 10};
        tbl[2] = '{"min3_3", 3, 3, 6, 3};
        tbl[3] = '{"p64h60", 60, 4, 64, 60};
        tbl[4] = '{"p120h57", 57, 63, 120, 57};
        repeat (3) @(negedge clk_50m);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_period", period, 0);
        chk("rst_high", high_time, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk_50m);
        foreach (tbl[i]) measure(tbl[i].name, tbl[i].hi, tbl[i].lo, tbl[i].ep, tbl[i].eh);
        for (int k = 0; k < 10; k++) begin
            int h = int'($urandom_range(3, 60));
            int l = int'($urandom_range(3, 60));
            measure($sformatf("rand%0d", k), h, l, ref_period(h, l), h);
        end
        // clk_in idle: busy lasts while cnt walks 0..TMO, then timeout
        gen_en = 1'b0;
        repeat (200) @(negedge clk_50m);
        @(negedge clk_50m);
        start = 1'b1;
        @(negedge clk_50m);
        start = 1'b0;
        n = 0;
        seen = 1'b0;
        while (busy && n < 2 * TMO) begin
            if (valid) seen = 1'b1;
            n++;
            @(negedge clk_50m);
        end
        chk("tmo_busy_cycles", n, TMO + 1);
        chk("tmo_flag", timeout, 1);
        chk("tmo_no_valid", seen, 0);
        chk("tmo_period_kept", period, last_p);
        chk("tmo_high_kept", high_time, last_h);
        hi_len = 25;
        lo_len = 25;
        gen_en = 1'b1;
        repeat (100) @(negedge clk_50m);
        pulse_start();
        chk("tmo_cleared_by_start", timeout, 0);
        wait_valid("hold");
        chk("hold_period", period, 50);
        chk("hold_high", high_time, 25);
        bad = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_50m);
            if (valid !== 1'b1 || period !== 32'd50 || high_time !== 32'd25) bad++;
        end
        chk("hold_stable_cycles_bad", bad, 0);
        ready = 1'b1;
        @(negedge clk_50m);
        ready = 1'b0;
        chk("hold_release_valid", valid, 0);
        chk("hold_release_busy", busy, 0);
        hi_len = 10;
        lo_len = 30;
        repeat (100) @(negedge clk_50m);
        pulse_start();
        wait_valid("sih");
        chk("sih_period", period, 40);
        start = 1'b1;
        ready = 1'b1;
        @(negedge clk_50m);
        start = 1'b0;
        ready = 1'b0;
        chk("sih_valid", valid, 0);
        chk("sih_busy", busy, 0);
        seen = 1'b0;
        repeat (100) begin
            @(negedge clk_50m);
            if (busy || valid) seen = 1'b1;
        end
        chk("sih_no_restart", seen, 0);
        hi_len = 25;
        lo_len = 25;
        repeat (100) @(negedge clk_50m);
        wait_clk_in_rise();
        pulse_start();
        repeat (20) @(negedge clk_50m);
        chk("mid_busy_before_reset", busy, 1);
        #5;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_timeout", timeout, 0);
        chk("mid_rst_period", period, 0);
        chk("mid_rst_high", high_time, 0);
        repeat (3) @(negedge clk_50m);
        reset = 1'b0;
        repeat (5) @(negedge clk_50m);
        measure("after_rst", 25, 25, 50, 25);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/clk_period_meter.md
CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 The block SHALL expose the following parameters: SYNC_STAGES, default 2, input synchronizer depth (>=2).
REQ-002 CNT_W, default 32, width of the measurement counter and results.
REQ-003 TIMEOUT, default 100_000_000, maximum clk_50m cycles allowed while waiting for an edge.
REQ-004 The block SHALL have the following ports; reset is asynchronous, active-high, and the clock is clk_50m:
  clk_50m    in   1      system clock, 50 MHz
  reset      in   1      asynchronous, active-high reset
  clk_in     in   1      slow clock under measurement; asynchronous to clk_50m
  start      in   1      single-cycle arm request
  ready      in   1      consumer accepts the result
  valid      out  1      result available
  period     out  CNT_W  rising-to-rising interval in clk_50m cycles
  high_time  out  CNT_W  rising-to-falling interval in clk_50m cycles
  busy       out  1      high in every state except IDLE
  timeout    out  1      sticky error flag

Function
REQ-005 clk_in SHALL pass through a SYNC_STAGES flip-flop chain and then one edge register, producing single-cycle rise and fall pulses.
REQ-006 Rise and fall pulses SHALL be suppressed for the first SYNC_STAGES+1 cycles after reset release (warm-up).
REQ-007 The FSM SHALL have exactly four states: IDLE, WAIT_RISE, MEASURE and HOLD.
REQ-008 In IDLE, start SHALL move the FSM to WAIT_RISE, clear cnt to 0 and clear timeout.
REQ-009 start SHALL be ignored in all states other than IDLE.
REQ-010 In WAIT_RISE, cnt SHALL increment each cycle, and a rise pulse SHALL move the FSM to MEASURE with cnt loaded to 1.
REQ-011 In MEASURE, cnt SHALL increment each cycle, and a fall pulse SHALL load high_time with cnt.
REQ-012 In MEASURE, a rise pulse SHALL load period with cnt and move the FSM to HOLD; period equals the exact edge-to-edge distance N.
REQ-013 Synchronizer latency SHALL be constant and SHALL therefore not bias the period or high_time results.
REQ-014 In HOLD, valid SHALL be 1, period and high_time SHALL be held stable, and clk_in edges SHALL be ignored.
REQ-015 In HOLD, valid and ready high in the same cycle SHALL complete the transfer, and the FSM SHALL return to IDLE on the next cycle.
REQ-016 valid SHALL NOT depend combinationally on ready.
REQ-017 If cnt reaches TIMEOUT in WAIT_RISE or MEASURE, the FSM SHALL go to IDLE and set timeout to 1; period and high_time SHALL remain unchanged.
REQ-018 timeout SHALL hold until the next accepted start or reset.
REQ-019 cnt SHALL never wrap; TIMEOUT < 2^CNT_W is a parameter legality requirement, and a violation SHALL be flagged in elaboration.
REQ-020 If a rise and a TIMEOUT hit occur in the same cycle, the rise SHALL take priority.
REQ-021 clk_in high and low phases SHALL each be at least SYNC_STAGES+1 clk_50m cycles; narrower pulses are unsupported.
REQ-022 Results SHALL be unsigned; period and high_time SHALL be registered outputs.

Reset
REQ-023 Asserting reset SHALL immediately force state to IDLE and set valid, busy, timeout, period, high_time, cnt, all synchronizer flops and the edge register to 0.
REQ-024 Reset mid-measurement SHALL abort with no partial result presented.
REQ-025 After reset release, the warm-up period of REQ-006 SHALL apply.

Structure
REQ-026 Package clk_meter_pkg SHALL hold the FSM state enum and the default values of SYNC_STAGES, CNT_W and TIMEOUT.
REQ-027 The synchronizer, edge register and warm-up counter SHALL be a sub-module named sync_edge_det, with outputs rise and fall.
REQ-028 The FSM, counter, result registers and handshake SHALL reside in clk_period_meter.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- clk_in period 50 cycles, 25 high; start -> valid=1, period=50, high_time=25.
- clk_in 10 high / 30 low; start -> period=40, high_time=10.
- clk_in held low, TIMEOUT=1000; start -> timeout=1, busy=0 after 1000 cycles; valid never 1.
- Result pending with ready low for 200 cycles while clk_in toggles -> valid, period and high_time constant; ready=1 -> valid=0 next cycle, busy=0.
- reset pulsed mid-MEASURE -> all outputs 0; a new start after warm-up measures correctly.
- start pulsed during HOLD, with ready high in the same cycle -> transfer completes, FSM in IDLE, no new measurement started.
